iram_prog_loader: RTL and testbench



---
 rtl/iram_prog_loader.sv | 191 +++++++++++++++++++
 tb/tb_iram_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_prog_loader.sv
// ---------------------------------------------------------------------------
// iram_prog_loader
//
// Streams 32-bit host words into 128-bit IRAM program lines and writes each
// completed line to the IRAM program port. The CPU is held in reset
// (cpu_rst_b low) from power-up and for the whole load. It is released once
// every requested line has been written.
//
// Optional feature: define IRAM_LOADER_CHKSUM_EN to build a running modulo-2^32
// sum of every transferred word on chksum. Without the macro, chksum is a
// constant 0 and no adder is built.
//
// Parameters
//   LINE_AW          IRAM line-address width in bits
//
// Ports
//   pll_core_cpuclk  in   sole clock, rising edge
//   pad_cpu_rst      in   synchronous active-high reset
//   start            in   single-cycle load request (accepted in IDLE/DONE)
//   base_waddr       in   first line address, sampled on accepted start
//   line_cnt         in   number of 128-bit lines, sampled on accepted start
//   ld_valid         in   host word valid
//   ld_data          in   host word
//   ld_ready         out  loader accepts a word (FILL only)
//   prog_wen         out  one-cycle IRAM program-write strobe
//   prog_waddr       out  IRAM program-write line address (held between writes)
//   prog_wdata       out  IRAM program-write data (held between writes)
//   cpu_rst_b        out  active-low CPU release, high only in DONE
//   busy             out  load in progress (FILL or WRITE)
//   done             out  load complete
//   chksum           out  load checksum (see macro above)
// ---------------------------------------------------------------------------
module iram_prog_loader #(
  parameter int LINE_AW = 20
) (
  input  logic               pll_core_cpuclk,
  input  logic               pad_cpu_rst,
  input  logic               start,
  input  logic [LINE_AW-1:0] base_waddr,
  input  logic [LINE_AW-1:0] line_cnt,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  output logic               ld_ready,
  output logic               prog_wen,
  output logic [LINE_AW-1:0] prog_waddr,
  output logic [127:0]       prog_wdata,
  output logic               cpu_rst_b,
  output logic               busy,
  output logic               done,
  output logic [31:0]        chksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               start_acc;
  logic               xfer;
  logic               last_word;

  logic [1:0]         word_idx_q;
  logic [LINE_AW-1:0] remain_q;
  logic [LINE_AW-1:0] addr_q;

  logic [95:0]        pack_p0;
  logic [127:0]       wr_data_p1;
  logic [LINE_AW-1:0] wr_addr_p1;

  // A start while a load is running is dropped, not queued.
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  // ld_ready is only high in FILL, so a start coincident with ld_valid in DONE
  // can never move a word.
  assign xfer      = (state_q == FILL) && ld_valid;
  assign last_word = xfer && (word_idx_q == 2'd3);

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    prog_wen  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cpu_rst_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = (line_cnt != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (last_word) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        prog_wen = 1'b1;
        busy     = 1'b1;
        state_d  = (remain_q == LINE_AW'(1)) ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst_b = 1'b1;
        if (start_acc) begin
          state_d = (line_cnt != '0) ? FILL : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load control: word index within the line, lines left, next line address.
  // Clearing word_idx_q on reset is what discards a partially packed line.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      word_idx_q <= '0;
      remain_q   <= '0;
      addr_q     <= '0;
    end else if (start_acc) begin
      word_idx_q <= '0;
      remain_q   <= line_cnt;
      addr_q     <= base_waddr;
    end else if (state_q == WRITE) begin
      remain_q   <= remain_q - LINE_AW'(1);
      addr_q     <= addr_q + LINE_AW'(1);   // wraps modulo 2^LINE_AW
    end else if (xfer) begin
      word_idx_q <= word_idx_q + 2'd1;
    end
  end

  // ---- stage p0: pack words 0..2 of the current line ----
  always_ff @(posedge pll_core_cpuclk) begin
    if (xfer) begin
      case (word_idx_q)
        2'd0:    pack_p0[31:0]  <= ld_data;
        2'd1:    pack_p0[63:32] <= ld_data;
        2'd2:    pack_p0[95:64] <= ld_data;
        default: pack_p0        <= pack_p0;
      endcase
    end
  end

  // ---- stage p1: completed line, presented during WRITE and held after ----
  // Kept apart from pack_p0 so the write port stays stable while the next
  // line is being packed.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      wr_data_p1 <= '0;
      wr_addr_p1 <= '0;
    end else if (last_word) begin
      wr_data_p1 <= {ld_data, pack_p0};
      wr_addr_p1 <= addr_q;
    end
  end

  assign prog_wdata = wr_data_p1;
  assign prog_waddr = wr_addr_p1;

`ifdef IRAM_LOADER_CHKSUM_EN
  logic [31:0] chksum_q;

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      chksum_q <= '0;
    end else if (start_acc) begin
      chksum_q <= '0;
    end else if (xfer) begin
      chksum_q <= chksum_q + ld_data;
    end
  end

  assign chksum = chksum_q;
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_iram_prog_loader.sv
module tb_iram_prog_loader;

  localparam int LINE_AW = 20;

  logic               clk = 1'b0;
  logic               pad_cpu_rst;
  logic               start;
  logic [LINE_AW-1:0] base_waddr;
  logic [LINE_AW-1:0] line_cnt;
  logic               ld_valid;
  logic [31:0]        ld_data;
  logic               ld_ready;
  logic               prog_wen;
  logic [LINE_AW-1:0] prog_waddr;
  logic [127:0]       prog_wdata;
  logic               cpu_rst_b;
  logic               busy;
  logic               done;
  logic [31:0]        chksum;

  typedef struct {
    logic [LINE_AW-1:0] a;
    logic [127:0]       d;
  } wr_t;

  wr_t                exp_q[$];
  logic [31:0]        words_q[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 wen_cnt = 0;
  logic [31:0]        tb_sum;
  logic [LINE_AW-1:0] last_a;
  logic [127:0]       last_d;

  iram_prog_loader #(.LINE_AW(LINE_AW)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (pad_cpu_rst),
    .start           (start),
    .base_waddr      (base_waddr),
    .line_cnt        (line_cnt),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data),
    .ld_ready        (ld_ready),
    .prog_wen        (prog_wen),
    .prog_waddr      (prog_waddr),
    .prog_wdata      (prog_wdata),
    .cpu_rst_b       (cpu_rst_b),
    .busy            (busy),
    .done            (done),
    .chksum          (chksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every prog_wen cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (prog_wen === 1'b1) begin
      wr_t e;
      wen_cnt++;
      chk("wen_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 128'(prog_waddr), 128'(e.a));
        chk("wr_data", prog_wdata, e.d);
      end
    end
  end

  function automatic logic [31:0] exp_chk(input logic [31:0] s);
`ifdef IRAM_LOADER_CHKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld_ready"},   128'(ld_ready),   '0);
    chk({tag, "_prog_wen"},   128'(prog_wen),   '0);
    chk({tag, "_prog_waddr"}, 128'(prog_waddr), '0);
    chk({tag, "_prog_wdata"}, prog_wdata,       '0);
    chk({tag, "_cpu_rst_b"},  128'(cpu_rst_b),  '0);
    chk({tag, "_busy"},       128'(busy),       '0);
    chk({tag, "_done"},       128'(done),       '0);
    chk({tag, "_chksum"},     128'(chksum),     '0);
  endtask

  // Runs a full load using words_q. toggle inserts an idle cycle before every
  // word; poke fires an ignored start mid-FILL; coincide drives ld_valid with
  // the start itself.
  task automatic run_load(input string tag, input logic [LINE_AW-1:0] base,
                          input logic [LINE_AW-1:0] cnt, input bit toggle,
                          input bit poke, input bit coincide);
    logic [127:0] line;
    int n;
    start      = 1'b1;
    base_waddr = base;
    line_cnt   = cnt;
    if (coincide) begin
      ld_valid = 1'b1;
      ld_data  = 32'hDEADBEEF;
    end
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    tb_sum   = '0;
    chk({tag, "_busy_start"},  128'(busy),      128'(cnt != 0));
    chk({tag, "_done_start"},  128'(done),      128'(cnt == 0));
    chk({tag, "_rstb_start"},  128'(cpu_rst_b), 128'(cnt == 0));
    line = '0;
    for (int l = 0; l < int'(cnt); l++) begin
      for (int k = 0; k < 4; k++) begin
        if (toggle) begin
          ld_valid = 1'b0;
          tick();
        end
        ld_valid = 1'b1;
        ld_data  = words_q[l*4+k];
        n = 0;
        while (!ld_ready && n < 20) begin
          tick();
          n++;
        end
        if (n >= 20) chk({tag, "_ready_timeout"}, 128'(ld_ready), 128'(1));
        line[32*k +: 32] = ld_data;
        if (k == 3) begin
          wr_t e;
          e.a = base + LINE_AW'(l);
          e.d = line;
          exp_q.push_back(e);
          last_a = e.a;
          last_d = e.d;
        end
        tick();
        tb_sum = tb_sum + ld_data;
        if (poke && l == 0 && k == 0) begin
          ld_valid   = 1'b0;
          start      = 1'b1;
          base_waddr = 20'h00099;
          line_cnt   = 20'd5;
          tick();
          start = 1'b0;
        end
      end
    end
    ld_valid = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    tick();
    chk({tag, "_done"},    128'(done),          128'(1));
    chk({tag, "_rstb"},    128'(cpu_rst_b),     128'(1));
    chk({tag, "_busy"},    128'(busy),          128'(0));
    chk({tag, "_pending"}, 128'(exp_q.size()),  128'(0));
    chk({tag, "_chksum"},  128'(chksum),        128'(exp_chk(tb_sum)));
    if (cnt != 0) begin
      chk({tag, "_hold_addr"}, 128'(prog_waddr), 128'(last_a));
      chk({tag, "_hold_data"}, prog_wdata,       last_d);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    pad_cpu_rst = 1'b1;
    start       = 1'b0;
    base_waddr  = '0;
    line_cnt    = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    tick();
    tick();
    check_reset_outputs("rst");
    pad_cpu_rst = 1'b0;
    tick();
    chk("idle_rstb", 128'(cpu_rst_b), 128'(0));

    // Two-line streaming load, words 0..7.
    words_q.delete();
    for (int i = 0; i < 8; i++) words_q.push_back(32'(i));
    run_load("stream", 20'h00010, 20'd2, 1'b0, 1'b0, 1'b0);
    chk("stream_last_line", prog_wdata, 128'h00000007_00000006_00000005_00000004);

    // Same load with ld_valid toggling.
    run_load("toggle", 20'h00010, 20'd2, 1'b1, 1'b0, 1'b0);

    // Zero-length load: straight to DONE, no write.
    w0 = wen_cnt;
    run_load("zero", 20'h00123, 20'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_no_wen", 128'(wen_cnt), 128'(w0));

    // Address wrap.
    run_load("wrap", 20'hFFFFF, 20'd2, 1'b0, 1'b0, 1'b0);

    // Start coincident with ld_valid in DONE, and an ignored start mid-FILL.
    words_q.delete();
    for (int i = 0; i < 4; i++) words_q.push_back(32'hA0 + 32'(i));
    run_load("coinc", 20'h00040, 20'd1, 1'b0, 1'b1, 1'b1);

    // Checksum wrap case.
    words_q.delete();
    words_q.push_back(32'hFFFFFFFF);
    words_q.push_back(32'h1);
    words_q.push_back(32'h2);
    words_q.push_back(32'h3);
    run_load("chk", 20'h00200, 20'd1, 1'b0, 1'b0, 1'b0);
`ifdef IRAM_LOADER_CHKSUM_EN
    chk("chk_value", 128'(chksum), 128'h5);
`else
    chk("chk_value", 128'(chksum), 128'h0);
`endif

    // Reset after the 2nd word of a line: nothing written, all outputs 0.
    w0 = wen_cnt;
    start      = 1'b1;
    base_waddr = 20'h00020;
    line_cnt   = 20'd1;
    tick();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'h11111111;
    tick();
    ld_data  = 32'h22222222;
    tick();
    ld_valid    = 1'b0;
    pad_cpu_rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    pad_cpu_rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_wen", 128'(wen_cnt), 128'(w0));
    chk("abort_idle_busy", 128'(busy), 128'(0));

    // Clean load after the abort.
    words_q.delete();
    for (int i = 0; i < 8; i++) words_q.push_back(32'(i));
    run_load("post", 20'h00010, 20'd2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
